// File: rtl/jc_seq_checker_if.sv
// Johnson-code monitor bus: sampled code in, decoded index and link-health status out.
// master drives the code stream; slave is the checker.
interface jc_seq_checker_if #(
   parameter int WIDTH = 4,
   parameter int IW    = $clog2(2 * WIDTH)
);
   logic             in_valid;
   logic [WIDTH-1:0] code_in;
   logic [IW-1:0]    idx_out;
   logic             idx_valid;
   logic             illegal;
   logic             seq_err;
   logic             locked;
   logic [7:0]       err_cnt;

   modport master (
      output in_valid, code_in,
      input  idx_out, idx_valid, illegal, seq_err, locked, err_cnt
   );

   modport slave (
      input  in_valid, code_in,
      output idx_out, idx_valid, illegal, seq_err, locked, err_cnt
   );
endinterface

// File: rtl/jc_seq_checker.sv
// Johnson sequence checker: decode, acquire/hold lock, flag illegal codes and sequence errors.
// All outputs registered, 1-cycle latency; no backpressure. JC_HOLD_ALLOW_EN accepts stalled codes.
module jc_seq_checker #(
   parameter int WIDTH     = 4,
   parameter int LOCK_CNT  = 2,
   parameter int ERR_LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst,
   jc_seq_checker_if.slave  jc_bus
);
   localparam int IW = $clog2(2 * WIDTH);
   localparam logic [WIDTH-1:0] ONES    = '1;
   localparam logic [IW-1:0]    LAST_IX = IW'(2 * WIDTH - 1);
   localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
   localparam logic [3:0]       ERR_C   = 4'(ERR_LIMIT);

   typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQ, ST_LOCKED} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] prev_q, prev_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [3:0]    step_q, step_d;
   logic [3:0]    miss_q, miss_d;
   logic          iv_q, iv_d;
   logic          ill_q, ill_d;
   logic          se_q, se_d;
   logic [7:0]    ec_q, ec_d;

   logic          dec_legal;
   logic [IW-1:0] dec_idx;
   logic [IW-1:0] exp_idx;
   logic          hold_ok;

   // Legal words: k leading ones then zeros (idx k), or k leading zeros then ones (idx WIDTH+k).
   always_comb begin
      dec_legal = 1'b0;
      dec_idx   = '0;
      for (int k = 0; k <= WIDTH; k++) begin
         if (jc_bus.code_in == ~(ONES >> k)) begin
            dec_legal = 1'b1;
            dec_idx   = IW'(k);
         end
      end
      for (int k = 1; k < WIDTH; k++) begin
         if (jc_bus.code_in == (ONES >> k)) begin
            dec_legal = 1'b1;
            dec_idx   = IW'(WIDTH + k);
         end
      end
   end

   assign exp_idx = (prev_q == LAST_IX) ? '0 : prev_q + IW'(1);

`ifdef JC_HOLD_ALLOW_EN
   assign hold_ok = dec_legal && (dec_idx == prev_q);
`else
   assign hold_ok = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      idx_d   = idx_q;
      step_d  = step_q;
      miss_d  = miss_q;
      iv_d    = 1'b0;
      ill_d   = 1'b0;
      se_d    = 1'b0;
      ec_d    = ec_q;
      if (jc_bus.in_valid) begin
         iv_d  = dec_legal;
         ill_d = ~dec_legal;
         if (dec_legal) begin
            idx_d = dec_idx;
         end
         unique case (state_q)
            ST_UNLOCKED: begin
               if (dec_legal) begin
                  prev_d  = dec_idx;
                  step_d  = '0;
                  state_d = ST_ACQ;
               end
            end
            ST_ACQ: begin
               if (!dec_legal) begin
                  state_d = ST_UNLOCKED;
               end else if (dec_idx == exp_idx) begin
                  prev_d = dec_idx;
                  step_d = step_q + 4'd1;
                  if (step_q + 4'd1 == LOCK_C) begin
                     state_d = ST_LOCKED;
                     miss_d  = '0;
                  end
               end else if (!hold_ok) begin
                  prev_d = dec_idx;
                  step_d = '0;
               end
            end
            ST_LOCKED: begin
               if (dec_legal && (dec_idx == exp_idx)) begin
                  prev_d = dec_idx;
                  miss_d = '0;
               end else if (!hold_ok) begin
                  // Flywheel on the expected index so one glitch does not derail tracking.
                  se_d   = 1'b1;
                  prev_d = exp_idx;
                  miss_d = miss_q + 4'd1;
                  if (ec_q != 8'hFF) begin
                     ec_d = ec_q + 8'd1;
                  end
                  if (miss_q + 4'd1 == ERR_C) begin
                     state_d = ST_UNLOCKED;
                  end
               end
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_UNLOCKED;
         prev_q  <= '0;
         idx_q   <= '0;
         step_q  <= '0;
         miss_q  <= '0;
         iv_q    <= 1'b0;
         ill_q   <= 1'b0;
         se_q    <= 1'b0;
         ec_q    <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         idx_q   <= idx_d;
         step_q  <= step_d;
         miss_q  <= miss_d;
         iv_q    <= iv_d;
         ill_q   <= ill_d;
         se_q    <= se_d;
         ec_q    <= ec_d;
      end
   end

   assign jc_bus.idx_out   = idx_q;
   assign jc_bus.idx_valid = iv_q;
   assign jc_bus.illegal   = ill_q;
   assign jc_bus.seq_err   = se_q;
   assign jc_bus.locked    = (state_q == ST_LOCKED);
   assign jc_bus.err_cnt   = ec_q;
endmodule

// File: tb/tb_jc_seq_checker.sv
// Bench for jc_seq_checker: directed vector table, async-reset sequence, randomized stream vs reference model.
module tb_jc_seq_checker;
   localparam int WIDTH     = 4;
   localparam int LOCK_CNT  = 2;
   localparam int ERR_LIMIT = 3;
   localparam int NST       = 2 * WIDTH;

`ifdef JC_HOLD_ALLOW_EN
   localparam logic       STALL_SE = 1'b0;
   localparam logic [7:0] STALL_EC = 8'd4;
   localparam bit         HOLD_EN  = 1'b1;
`else
   localparam logic       STALL_SE = 1'b1;
   localparam logic [7:0] STALL_EC = 8'd5;
   localparam bit         HOLD_EN  = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   jc_seq_checker_if #(.WIDTH(WIDTH)) jif ();

   jc_seq_checker #(
      .WIDTH    (WIDTH),
      .LOCK_CNT (LOCK_CNT),
      .ERR_LIMIT(ERR_LIMIT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .jc_bus(jif)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input int idx, input logic iv, input logic ill,
                           input logic se, input logic lk, input int ec);
      chk({tag, ".idx_out"},   32'(jif.idx_out),   32'(idx));
      chk({tag, ".idx_valid"}, 32'(jif.idx_valid), 32'(iv));
      chk({tag, ".illegal"},   32'(jif.illegal),   32'(ill));
      chk({tag, ".seq_err"},   32'(jif.seq_err),   32'(se));
      chk({tag, ".locked"},    32'(jif.locked),    32'(lk));
      chk({tag, ".err_cnt"},   32'(jif.err_cnt),   32'(ec));
   endtask

   // Reference: legal codes come from running a behavioural Johnson counter.
   logic [WIDTH-1:0] jseq [NST];
   int m_mode, m_prev, m_step, m_miss, m_ec, m_idx;
   bit m_iv, m_ill, m_se;

   task automatic model_reset();
      m_mode = 0; m_prev = 0; m_step = 0; m_miss = 0; m_ec = 0; m_idx = 0;
      m_iv = 0; m_ill = 0; m_se = 0;
   endtask

   task automatic model_step(input logic v, input logic [WIDTH-1:0] c);
      int k;
      int nxt;
      bit stall;
      m_iv = 0; m_ill = 0; m_se = 0;
      if (!v) return;
      k = -1;
      for (int i = 0; i < NST; i++) if (jseq[i] == c) k = i;
      nxt   = (m_prev + 1) % NST;
      stall = HOLD_EN && (k == m_prev);
      if (k >= 0) begin m_iv = 1; m_idx = k; end
      else m_ill = 1;
      if (m_mode == 0) begin
         if (k >= 0) begin m_prev = k; m_step = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
         if (k < 0) m_mode = 0;
         else if (k == nxt) begin
            m_prev = k; m_step++;
            if (m_step == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
         end else if (!stall) begin
            m_prev = k; m_step = 0;
         end
      end else begin
         if (k == nxt) begin m_prev = k; m_miss = 0; end
         else if (!stall) begin
            m_se = 1;
            if (m_ec < 255) m_ec++;
            m_miss++;
            m_prev = nxt;
            if (m_miss == ERR_LIMIT) m_mode = 0;
         end
      end
   endtask

   task automatic apply(input logic v, input logic [WIDTH-1:0] c);
      @(negedge clk);
      jif.in_valid = v;
      jif.code_in  = c;
      @(posedge clk);
      model_step(v, c);
      #1;
   endtask

   typedef struct {
      logic       vld;
      logic [3:0] code;
      int         idx;
      logic       iv, ill, se, lk;
      int         ec;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic v, input logic [3:0] c, input int idx, input logic iv,
                               input logic ill, input logic se, input logic lk, input int ec);
      vec_t t;
      t.vld = v; t.code = c; t.idx = idx; t.iv = iv; t.ill = ill; t.se = se; t.lk = lk; t.ec = ec;
      tbl.push_back(t);
   endfunction

   initial begin
      logic [WIDTH-1:0] c;
      int p;
      c = '0;
      for (int i = 0; i < NST; i++) begin
         jseq[i] = c;
         c = {~c[0], c[WIDTH-1:1]};
      end

      //     vld code     idx iv ill se lk ec
      add(1, 4'b1010, 0, 0, 1, 0, 0, 0);
      add(1, 4'b0000, 0, 1, 0, 0, 0, 0);
      add(1, 4'b0110, 0, 0, 1, 0, 0, 0);
      add(1, 4'b0000, 0, 1, 0, 0, 0, 0);
      add(1, 4'b1000, 1, 1, 0, 0, 0, 0);
      add(1, 4'b1100, 2, 1, 0, 0, 1, 0);
      add(1, 4'b1110, 3, 1, 0, 0, 1, 0);
      add(1, 4'b1111, 4, 1, 0, 0, 1, 0);
      add(1, 4'b0111, 5, 1, 0, 0, 1, 0);
      add(1, 4'b0011, 6, 1, 0, 0, 1, 0);
      add(1, 4'b0001, 7, 1, 0, 0, 1, 0);
      add(1, 4'b0000, 0, 1, 0, 0, 1, 0);
      add(1, 4'b1000, 1, 1, 0, 0, 1, 0);
      add(1, 4'b1100, 2, 1, 0, 0, 1, 0);
      add(1, 4'b1010, 2, 0, 1, 1, 1, 1);
      add(1, 4'b1111, 4, 1, 0, 0, 1, 1);
      add(1, 4'b0000, 0, 1, 0, 1, 1, 2);
      add(1, 4'b0000, 0, 1, 0, 1, 1, 3);
      add(1, 4'b0000, 0, 1, 0, 1, 0, 4);
      add(1, 4'b1000, 1, 1, 0, 0, 0, 4);
      add(1, 4'b0011, 6, 1, 0, 0, 0, 4);
      add(1, 4'b0001, 7, 1, 0, 0, 0, 4);
      add(1, 4'b0000, 0, 1, 0, 0, 1, 4);
      add(1, 4'b1000, 1, 1, 0, 0, 1, 4);
      add(1, 4'b1100, 2, 1, 0, 0, 1, 4);
      add(1, 4'b1100, 2, 1, 0, STALL_SE, 1, int'(STALL_EC));
      for (int i = 0; i < 5; i++) add(0, 4'b1010, 2, 0, 0, 0, 1, int'(STALL_EC));

      rst = 1'b1;
      jif.in_valid = 1'b0;
      jif.code_in  = '0;
      model_reset();
      #12;
      chk_outs("reset", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         apply(tbl[i].vld, tbl[i].code);
         chk_outs($sformatf("vec%0d", i), tbl[i].idx, tbl[i].iv, tbl[i].ill,
                  tbl[i].se, tbl[i].lk, tbl[i].ec);
      end

      // Async reset between edges while locked with a nonzero error count.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_outs("async_rst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      apply(1, 4'b1110);
      chk_outs("post_rst", 3, 1, 0, 0, 0, 0);

      // Randomized stream: mostly clean progression with stalls, jumps and corrupt words.
      p = 3;
      for (int n = 0; n < 2000; n++) begin
         int r;
         logic v;
         logic [WIDTH-1:0] code;
         v = ($urandom_range(0, 99) < 85);
         r = $urandom_range(0, 99);
         if (r < 75) begin
            p = (p + 1) % NST;
            code = jseq[p];
         end else if (r < 85) begin
            code = jseq[p];
         end else if (r < 93) begin
            code = WIDTH'($urandom);
         end else begin
            p = $urandom_range(0, NST - 1);
            code = jseq[p];
         end
         apply(v, code);
         chk_outs($sformatf("rnd%0d", n), m_idx, m_iv, m_ill, m_se, (m_mode == 2), m_ec);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/jc_seq_checker.md
Name: jc_seq_checker

Overview:
- Receive-side companion to the team's 4-bit Johnson counter.
- Samples a Johnson-coded word each valid cycle and decodes it to a binary phase index.
- Checks that successive words follow the legal Johnson progression, acquires and holds lock, and reports illegal codes and sequence errors.
- Sits downstream of any Johnson-counter output crossing a block or board boundary, as a link/health monitor.

Parameters:
- WIDTH, 4, Johnson code width; sequence length is 2*WIDTH states.
- LOCK_CNT, 2, consecutive correct steps required in ACQ before entering LOCKED (1..15).
- ERR_LIMIT, 3, consecutive bad samples in LOCKED that drop lock (1..15).
- IW (derived localparam), clog2(2*WIDTH), index width (3 for WIDTH=4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  code_in is sampled this cycle.
- code_in  input  WIDTH  Johnson-coded word.
- idx_out  output  IW  decoded index of the last legal sample.
- idx_valid  output  1  one-cycle pulse: idx_out updated from a legal sample.
- illegal  output  1  one-cycle pulse: sampled word is not a legal Johnson code.
- seq_err  output  1  one-cycle pulse: bad sample while LOCKED (illegal code or wrong successor).
- locked  output  1  level, high in LOCKED state.
- err_cnt  output  8  count of seq_err pulses, saturates at 255.

Behaviour:
- Reset: one clock (clk); asynchronous active-high reset (rst). While rst=1 all outputs are 0, the state is UNLOCKED, and the internal prev index and step/miss counters are 0.
- Decode (combinational, then registered):
  - If code_in MSB=1 or code_in=0: word must be k leading ones followed by zeros; idx=k.
  - Otherwise: word must be k leading zeros (1..WIDTH-1) followed by ones; idx=WIDTH+k.
  - Any other pattern is illegal.
  - WIDTH=4 mapping: 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7.
- Latency: all outputs are registered, 1 cycle after the sampling edge.
- in_valid=0: no state change; all pulses 0; idx_out holds.
- Expected successor: (prev+1) mod 2*WIDTH. Wraps 7→0 for WIDTH=4.
- UNLOCKED:
  - Legal sample: prev=idx, step=0, go to ACQ.
  - Illegal sample: stay in UNLOCKED.
- ACQ:
  - Legal sample equal to expected: prev=idx, step++. When step reaches LOCK_CNT, go to LOCKED with miss=0; locked rises on the same registered edge.
  - Legal sample not equal to expected: restart acquisition with prev=idx, step=0.
  - Illegal sample: go to UNLOCKED.
- LOCKED:
  - Sample equal to expected: prev=idx, miss=0.
  - Wrong successor or illegal code: seq_err pulse, err_cnt++ (saturating), miss++. Flywheel: prev=expected, so an isolated glitch does not break tracking.
  - When miss reaches ERR_LIMIT: go to UNLOCKED, locked falls.
- Pulses:
  - idx_valid pulses for every legal sample in any state; idx_out takes the decoded idx.
  - illegal pulses for every illegal sample in any state; idx_out holds.
  - seq_err pulses only in LOCKED.
- err_cnt is cleared only by rst; it holds across lock loss.
- Reset mid-operation: immediate return to reset values, including err_cnt and locked.

Optional Feature:
- Macro: JC_HOLD_ALLOW_EN.
- Defined: in ACQ and LOCKED, a legal sample equal to prev (counter stalled) is accepted. idx_valid pulses; step, miss and prev are unchanged; no seq_err. This supports a source with clock enable.
- Undefined: a repeated code is treated as a wrong successor (restart in ACQ, seq_err in LOCKED).

Test Plan:
- Reset/acquire: rst pulse, then feed 0000,1000,1100,1110 on consecutive valid cycles → idx_out 0,1,2,3. locked=1 the cycle after the 1100 sample (LOCK_CNT=2). seq_err=0, err_cnt=0.
- Wrap: locked, feed 0111,0011,0001,0000,1000 → idx_out 5,6,7,0,1; no seq_err; locked stays 1.
- Single glitch: locked with prev=2, feed 1010 then 1111 → cycle 1: illegal=1, seq_err=1, err_cnt=1. Cycle 2 (expected 4 via flywheel): accepted, no error, miss=0, locked=1.
- Lock loss: locked, feed three wrong successors (e.g. 0000 repeatedly after prev=3) → seq_err ×3, err_cnt=3, locked falls after the third; next legal word enters ACQ.
- Stall: feed 1100 twice while locked → without JC_HOLD_ALLOW_EN: seq_err=1, err_cnt+1. With JC_HOLD_ALLOW_EN: idx_valid=1, idx_out=2, no error.
- Async reset mid-stream and in_valid gaps: assert rst between clock edges while locked → all outputs 0 immediately. Deassert in_valid for 5 cycles while locked → outputs hold, no pulses, lock kept.
